// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Decode stage of the LEGv8 pipelined datapath. It latches the fetched
//   instruction and its PC in the IF/ID register, which supports stall and
//   flush. It holds the 32 x N architectural register file with write-back and
//   same-cycle bypass. It produces both read operands and the sign-extended
//   immediate for the execute stage.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset
//   imem_addr_F  in   N   PC of the instruction being fetched
//   instr_F      in   32  fetched instruction word
//   stall_D      in   1   hold IF/ID contents
//   flush_D      in   1   replace IF/ID contents with a bubble (beats stall)
//   regWrite_W   in   1   write-back enable
//   writeReg_W   in   5   write-back register index
//   writeData_W  in   N   write-back data
//   valid_D      out  1   IF/ID holds a real instruction
//   pc_D         out  N   latched PC
//   instr_D      out  32  latched instruction
//   readData1_D  out  N   operand Rn
//   readData2_D  out  N   operand Rm (R-format) or Rt (D/CB-format)
//   signImm_D    out  N   sign-extended immediate (unscaled)
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int N = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  imem_addr_F,
  input  logic [31:0]   instr_F,
  input  logic          stall_D,
  input  logic          flush_D,
  input  logic          regWrite_W,
  input  logic [4:0]    writeReg_W,
  input  logic [N-1:0]  writeData_W,
  output logic          valid_D,
  output logic [N-1:0]  pc_D,
  output logic [31:0]   instr_D,
  output logic [N-1:0]  readData1_D,
  output logic [N-1:0]  readData2_D,
  output logic [N-1:0]  signImm_D
);

  localparam logic [4:0]  XZR         = 5'd31;
  localparam logic [10:0] OP_LDUR     = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR     = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ      = 8'b1011_0100;
  localparam logic [5:0]  OP_B        = 6'b00_0101;

  // IF/ID pipeline register
  logic          valid_q, valid_d;
  logic [N-1:0]  pc_q,    pc_d;
  logic [31:0]   instr_q, instr_d;

  // Register file; entry 31 is never written and is kept at zero.
  logic [N-1:0]  rf_q [0:31];

  logic          wr_en_s;
  logic [4:0]    ra1_s;
  logic [4:0]    ra2_s;

  // IF/ID next-state: flush beats stall beats load (reset handled in the flop).
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case ({flush_D, stall_D})
      2'b10, 2'b11: begin
        valid_d = 1'b0;
        pc_d    = {N{1'b0}};
        instr_d = 32'd0;
      end
      2'b01: begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
      end
      2'b00: begin
        valid_d = 1'b1;
        pc_d    = imem_addr_F;
        instr_d = instr_F;
      end
      default: begin
        valid_d = 1'b0;
        pc_d    = {N{1'b0}};
        instr_d = 32'd0;
      end
    endcase
  end

  // IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= {N{1'b0}};
      instr_q <= 32'd0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // XZR writes are dropped; write-back is independent of stall/flush.
  assign wr_en_s = regWrite_W && (writeReg_W != XZR);

  // Register file storage: reset loads Xi = i and suppresses that cycle's write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) begin
        rf_q[i] <= N'(i);
      end
      rf_q[31] <= {N{1'b0}};
    end else if (wr_en_s) begin
      rf_q[writeReg_W] <= writeData_W;
    end else begin
      rf_q[31] <= {N{1'b0}};
    end
  end

  // Read addresses; bit 28 separates R-format (Rm) from D/CB-format (Rt).
  assign ra1_s = instr_q[9:5];
  assign ra2_s = instr_q[28] ? instr_q[4:0] : instr_q[20:16];

  // Read port 1 with XZR forcing and same-cycle write-back bypass.
  always_comb begin
    readData1_D = {N{1'b0}};
    if (ra1_s == XZR) begin
      readData1_D = {N{1'b0}};
    end else if (wr_en_s && (writeReg_W == ra1_s)) begin
      readData1_D = writeData_W;
    end else begin
      readData1_D = rf_q[ra1_s];
    end
  end

  // Read port 2 with XZR forcing and same-cycle write-back bypass.
  always_comb begin
    readData2_D = {N{1'b0}};
    if (ra2_s == XZR) begin
      readData2_D = {N{1'b0}};
    end else if (wr_en_s && (writeReg_W == ra2_s)) begin
      readData2_D = writeData_W;
    end else begin
      readData2_D = rf_q[ra2_s];
    end
  end

  // Immediate decode; anything unrecognised (including the bubble) gives zero.
  always_comb begin
    signImm_D = {N{1'b0}};
    if ((instr_q[31:21] == OP_LDUR) || (instr_q[31:21] == OP_STUR)) begin
      signImm_D = {{(N-9){instr_q[20]}}, instr_q[20:12]};
    end else if (instr_q[31:24] == OP_CBZ) begin
      signImm_D = {{(N-19){instr_q[23]}}, instr_q[23:5]};
    end else if (instr_q[31:26] == OP_B) begin
      signImm_D = {{(N-26){instr_q[25]}}, instr_q[25:0]};
    end else begin
      signImm_D = {N{1'b0}};
    end
  end

  assign valid_D = valid_q;
  assign pc_D    = pc_q;
  assign instr_D = instr_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Self-checking bench for decode_stage: a table of directed vectors, a few
//   hand-written multi-cycle sequences (bypass, XZR, stall, stall+flush,
//   mid-stream reset) and a randomized phase checked against a behavioural
//   model of the IF/ID register, register file and immediate rules.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int N = 64;

  logic          clk;
  logic          reset;
  logic [N-1:0]  imem_addr_F;
  logic [31:0]   instr_F;
  logic          stall_D;
  logic          flush_D;
  logic          regWrite_W;
  logic [4:0]    writeReg_W;
  logic [N-1:0]  writeData_W;
  logic          valid_D;
  logic [N-1:0]  pc_D;
  logic [31:0]   instr_D;
  logic [N-1:0]  readData1_D;
  logic [N-1:0]  readData2_D;
  logic [N-1:0]  signImm_D;

  decode_stage #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr_F (imem_addr_F),
    .instr_F     (instr_F),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .regWrite_W  (regWrite_W),
    .writeReg_W  (writeReg_W),
    .writeData_W (writeData_W),
    .valid_D     (valid_D),
    .pc_D        (pc_D),
    .instr_D     (instr_D),
    .readData1_D (readData1_D),
    .readData2_D (readData2_D),
    .signImm_D   (signImm_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [N-1:0] m_rf [0:31];
  logic         m_valid;
  logic [N-1:0] m_pc;
  logic [31:0]  m_instr;

  typedef struct {
    logic [31:0]  instr;
    logic [N-1:0] pc;
    logic         stall;
    logic         flush;
    logic         exp_valid;
    logic [N-1:0] exp_pc;
    logic [31:0]  exp_instr;
    logic [N-1:0] exp_rd1;
    logic [N-1:0] exp_rd2;
    logic [N-1:0] exp_imm;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [N-1:0] exp_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (regWrite_W && writeReg_W == a) return writeData_W;
    return m_rf[a];
  endfunction

  // Immediate as a signed integer value, then taken as 64-bit two's complement.
  function automatic logic [N-1:0] exp_imm(input logic [31:0] ins);
    longint v;
    logic [10:0] op11;
    logic [7:0]  op8;
    logic [5:0]  op6;
    op11 = ins[31:21];
    op8  = ins[31:24];
    op6  = ins[31:26];
    v = 0;
    if (op11 == 11'd1986 || op11 == 11'd1984) begin
      v = longint'(ins[20:12]);
      if (v >= 256) v = v - 512;
    end else if (op8 == 8'd180) begin
      v = longint'(ins[23:5]);
      if (v >= 262144) v = v - 524288;
    end else if (op6 == 6'd5) begin
      v = longint'(ins[25:0]);
      if (v >= 33554432) v = v - 67108864;
    end
    return 64'(v);
  endfunction

  task automatic check_all(input string tag);
    logic [4:0] a1, a2;
    a1 = m_instr[9:5];
    a2 = m_instr[28] ? m_instr[4:0] : m_instr[20:16];
    chk({tag, ".valid"}, {63'd0, valid_D}, {63'd0, m_valid});
    chk({tag, ".pc"},    pc_D, m_pc);
    chk({tag, ".instr"}, {32'd0, instr_D}, {32'd0, m_instr});
    chk({tag, ".rd1"},   readData1_D, exp_read(a1));
    chk({tag, ".rd2"},   readData2_D, exp_read(a2));
    chk({tag, ".imm"},   signImm_D, exp_imm(m_instr));
  endtask

  // Advance the model by one edge using the currently driven inputs, then the DUT.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = (i == 31) ? 64'd0 : 64'(i);
      m_valid = 1'b0; m_pc = 64'd0; m_instr = 32'd0;
    end else begin
      if (regWrite_W && writeReg_W != 5'd31) m_rf[writeReg_W] = writeData_W;
      if (flush_D) begin
        m_valid = 1'b0; m_pc = 64'd0; m_instr = 32'd0;
      end else if (!stall_D) begin
        m_valid = 1'b1; m_pc = imem_addr_F; m_instr = instr_F;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [N-1:0] pc,
                       input logic st, input logic fl);
    instr_F = ins; imem_addr_F = pc; stall_D = st; flush_D = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [8:0]  i9;
    logic [18:0] i19;
    logic [25:0] i26;
    logic [4:0]  r1, r2;
    i9 = 9'($urandom); i19 = 19'($urandom); i26 = 26'($urandom);
    r1 = 5'($urandom); r2 = 5'($urandom);
    case ($urandom_range(0, 4))
      0:       return {11'b111_1100_0010, i9, 2'b00, r1, r2};
      1:       return {11'b111_1100_0000, i9, 2'b00, r1, r2};
      2:       return {8'b1011_0100, i19, r2};
      3:       return {6'b00_0101, i26};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Directed table: runs right after reset, so Xi = i throughout.
    vecs[0] = '{32'h8B020020, 64'h10, 1'b0, 1'b0, 1'b1, 64'h10, 32'h8B020020, 64'd1,  64'd2, 64'd0};
    vecs[1] = '{32'hF85FF0A0, 64'h14, 1'b0, 1'b0, 1'b1, 64'h14, 32'hF85FF0A0, 64'd5,  64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{32'hB4000207, 64'h18, 1'b0, 1'b0, 1'b1, 64'h18, 32'hB4000207, 64'd16, 64'd7, 64'h10};
    vecs[3] = '{32'h16000000, 64'h1C, 1'b0, 1'b0, 1'b1, 64'h1C, 32'h16000000, 64'd0,  64'd0, 64'hFFFF_FFFF_FE00_0000};
    vecs[4] = '{32'hF8000083, 64'h20, 1'b0, 1'b0, 1'b1, 64'h20, 32'hF8000083, 64'd4,  64'd3, 64'd0};
    vecs[5] = '{32'h8B020020, 64'h24, 1'b0, 1'b1, 1'b0, 64'h0,  32'h0,        64'd0,  64'd0, 64'd0};
    vecs[6] = '{32'h8B1F03C0, 64'h28, 1'b0, 1'b0, 1'b1, 64'h28, 32'h8B1F03C0, 64'd30, 64'd0, 64'd0};

    reset = 1'b1; regWrite_W = 1'b0; writeReg_W = 5'd0; writeData_W = 64'd0;
    drive(32'h8B020020, 64'h40, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset.valid", {63'd0, valid_D}, 64'd0);
    chk("reset.pc", pc_D, 64'd0);
    chk("reset.instr", {32'd0, instr_D}, 64'd0);
    chk("reset.rd1", readData1_D, 64'd0);
    chk("reset.rd2", readData2_D, 64'd0);
    chk("reset.imm", signImm_D, 64'd0);

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].instr, vecs[v].pc, vecs[v].stall, vecs[v].flush);
      tick();
      chk($sformatf("vec%0d.valid", v), {63'd0, valid_D}, {63'd0, vecs[v].exp_valid});
      chk($sformatf("vec%0d.pc", v), pc_D, vecs[v].exp_pc);
      chk($sformatf("vec%0d.instr", v), {32'd0, instr_D}, {32'd0, vecs[v].exp_instr});
      chk($sformatf("vec%0d.rd1", v), readData1_D, vecs[v].exp_rd1);
      chk($sformatf("vec%0d.rd2", v), readData2_D, vecs[v].exp_rd2);
      chk($sformatf("vec%0d.imm", v), signImm_D, vecs[v].exp_imm);
    end

    // Bypass: write X1 while ADD X0,X1,X2 sits in IF/ID.
    drive(32'h8B020020, 64'h30, 1'b0, 1'b0);
    tick();
    drive(32'h0, 64'h34, 1'b1, 1'b0);
    regWrite_W = 1'b1; writeReg_W = 5'd1; writeData_W = 64'hAB;
    #1;
    chk("bypass.same", readData1_D, 64'hAB);
    tick();
    regWrite_W = 1'b0;
    #1;
    chk("bypass.after", readData1_D, 64'hAB);
    chk("bypass.rm", readData2_D, 64'd2);

    // XZR write: instruction with Rn = 31.
    drive(32'h8B1F03E0, 64'h38, 1'b0, 1'b0);
    tick();
    drive(32'h0, 64'h3C, 1'b1, 1'b0);
    regWrite_W = 1'b1; writeReg_W = 5'd31; writeData_W = 64'hAB;
    #1;
    chk("xzr.same", readData1_D, 64'd0);
    tick();
    regWrite_W = 1'b0;
    #1;
    chk("xzr.after", readData1_D, 64'd0);

    // Stall for 3 cycles with changing instr_F, then release.
    drive(32'hF8000083, 64'h100, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(32'h8B020020 + 32'(k), 64'h200 + 64'(k), 1'b1, 1'b0);
      tick();
      chk($sformatf("stall%0d.instr", k), {32'd0, instr_D}, 64'hF8000083);
      chk($sformatf("stall%0d.pc", k), pc_D, 64'h100);
      chk($sformatf("stall%0d.valid", k), {63'd0, valid_D}, 64'd1);
    end
    drive(32'hB4000207, 64'h300, 1'b0, 1'b0);
    tick();
    chk("unstall.instr", {32'd0, instr_D}, 64'hB4000207);
    chk("unstall.pc", pc_D, 64'h300);

    // Stall and flush together: bubble.
    drive(32'h16000000, 64'h304, 1'b1, 1'b1);
    tick();
    chk("stallflush.valid", {63'd0, valid_D}, 64'd0);
    chk("stallflush.instr", {32'd0, instr_D}, 64'd0);
    chk("stallflush.pc", pc_D, 64'd0);

    // Mid-stream reset: earlier write to X2 undone, concurrent write to X3 dropped.
    drive(32'h8B030040, 64'h400, 1'b0, 1'b0);
    regWrite_W = 1'b1; writeReg_W = 5'd2; writeData_W = 64'h55;
    tick();
    writeReg_W = 5'd3; writeData_W = 64'h99; reset = 1'b1;
    tick();
    reset = 1'b0; regWrite_W = 1'b0;
    drive(32'h8B030040, 64'h404, 1'b0, 1'b0);
    #1;
    chk("midreset.valid", {63'd0, valid_D}, 64'd0);
    tick();
    chk("midreset.x2", readData1_D, 64'd2);
    chk("midreset.x3", readData2_D, 64'd3);

    // Randomized phase against the model.
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 63) == 0);
      regWrite_W  = $urandom_range(0, 1) == 1;
      writeReg_W  = 5'($urandom);
      writeData_W = {$urandom, $urandom};
      drive(rand_instr(), {$urandom, $urandom}, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0);
      #1;
      check_all($sformatf("rand%0d", c));
      tick();
    end
    reset = 1'b0; regWrite_W = 1'b0;
    #1;
    check_all("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the LEGv8 pipelined datapath, directly downstream of the fetch stage. Latches the fetched instruction and its PC in an IF/ID pipeline register with stall and flush control. Holds the 32×N architectural register file with write-back and bypass. Produces the two register operands and the sign-extended immediate for the execute stage.

## Interface
Parameters:
- N, 64, datapath and register width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr_F  in  N  PC of the instruction being fetched.
- instr_F  in  32  instruction word read from instruction memory at imem_addr_F.
- stall_D  in  1  hold the IF/ID register contents.
- flush_D  in  1  replace the IF/ID contents with a bubble.
- regWrite_W  in  1  write-back enable.
- writeReg_W  in  5  write-back register index.
- writeData_W  in  N  write-back data.
- valid_D  out  1  IF/ID holds a real instruction.
- pc_D  out  N  latched PC.
- instr_D  out  32  latched instruction.
- readData1_D  out  N  operand Rn.
- readData2_D  out  N  operand Rm or Rt.
- signImm_D  out  N  sign-extended immediate.

## Operation
- IF/ID register priority on each rising edge: reset > flush_D > stall_D > load.
  - reset or flush_D: instr_D=0, pc_D=0, valid_D=0.
  - stall_D alone: all three hold.
  - Otherwise: instr_D<=instr_F, pc_D<=imem_addr_F, valid_D<=1.
- Register file: 32 entries of N bits. X31 (XZR) always reads 0 and ignores writes.
  - Write on the rising edge when regWrite_W=1 and writeReg_W≠31.
  - Writes are independent of stall_D and flush_D.
- Reset initialises Xi = i for i = 0..30. A reset cycle also suppresses any write-back in that cycle.
- Read addresses:
  - ra1 = instr_D[9:5].
  - ra2 = instr_D[28] ? instr_D[4:0] : instr_D[20:16] (Reg2Loc).
- Reads are combinational from instr_D. A read returns 0 when its address is 31.
- Same-cycle bypass: if regWrite_W=1, writeReg_W = read address, and the address is not 31, that port returns writeData_W.
- signImm_D, decoded from instr_D:
  - instr_D[31:21] = 11111000010 (LDUR) or 11111000000 (STUR): sign-extend instr_D[20:12].
  - instr_D[31:24] = 10110100 (CBZ): sign-extend instr_D[23:5].
  - instr_D[31:26] = 000101 (B): sign-extend instr_D[25:0].
  - Any other opcode, including the bubble: 0.
- Sign extension replicates the top immediate bit up to bit N-1. No scaling; the branch shift-by-2 is done downstream.

## Timing
- Instruction latency from fetch: one cycle. The instruction presented with imem_addr_F in cycle t appears on instr_D/pc_D in cycle t+1.
- readData and signImm are combinational from instr_D and register state. There is no extra latency.
- A write-back in cycle t is visible:
  - through the bypass in cycle t;
  - from storage from cycle t+1.
- Stall held for k cycles: outputs are unchanged for k cycles. The instruction on instr_F in the first non-stalled cycle is captured.
- Simultaneous stall_D and flush_D: flush wins.
- Reset mid-stream: the IF/ID register and the register file both return to their reset values at that edge.

## Test plan
- Reset, then release: valid_D=0, instr_D=0, pc_D=0. With instr_D=0 (ra1=ra2=0), readData1_D=readData2_D=0 (X0=0). X5 reads 5 after any instruction with Rn=5.
- Load 0x8B020020 (ADD X0,X1,X2) at PC 0x10: next cycle pc_D=0x10, readData1_D=1, readData2_D=2, signImm_D=0, valid_D=1.
- LDUR with imm9=0x1FF (−1): signImm_D=0xFFFF_FFFF_FFFF_FFFF. CBZ with imm19=0x00010: signImm_D=0x10. B with imm26=0x2000000: signImm_D=0xFFFF_FFFF_FE00_0000.
- regWrite_W=1, writeReg_W=1, writeData_W=0xAB while instr_D reads X1: readData1_D=0xAB in the same cycle and after. The same write to X31 leaves X31 reading 0.
- STUR X3,[X4,#0] (instr_D[28]=1): ra2 = Rt = 3 and readData2_D=3.
- stall_D for 3 cycles with a changing instr_F: outputs frozen. Asserting stall_D and flush_D together: a bubble (valid_D=0, instr_D=0) next cycle.
